// File: rtl/mc_alu.sv
// Multi-cycle integer ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide. Define MC_ALU_DIV_EN to build the divider.
module mc_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carryout
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the result registers hold steady from out_valid until out_valid && out_ready.
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LUI   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_DIVU  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1101;
    localparam logic [3:0] OP_MULTU = 4'b1110;
    localparam logic [3:0] OP_DIV   = 4'b1111;

    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W:0]   CNT_ONE  = {{SHAMT_W{1'b0}}, 1'b1};
    localparam logic [SHAMT_W:0]   CNT_LAST = (SHAMT_W+1)'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MC_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, cy_q, cy_d;
    logic               out_valid_q, out_valid_d;
`ifdef MC_ALU_DIV_EN
    logic               neg_hi_q, neg_hi_d, div_zero_q, div_zero_d;
    logic               div_exc_q, div_exc_d, div_mode_q, div_mode_d;
    logic [WIDTH+1:0]   div_trial;
`endif

    logic [SHAMT_W-1:0] sa;
    logic [WIDTH:0]     add_s, sub_s, mul_sum;
    logic [WIDTH-1:0]   sc_lo, a_mag, b_mag, fix_lo, fix_hi;
    logic               sc_ov, sc_cy, fix_ov, is_mul, is_div, is_sgn;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        sa    = a[SHAMT_W-1:0];
        add_s = {1'b0, a} + {1'b0, b};
        sub_s = {1'b0, a} - {1'b0, b};
        sc_lo = '0;
        sc_ov = 1'b0;
        sc_cy = 1'b0;
        case (op)
            OP_AND:  sc_lo = a & b;
            OP_OR:   sc_lo = a | b;
            OP_ADD: begin
                sc_lo = add_s[MSB:0];
                sc_cy = add_s[WIDTH];
                sc_ov = (a[MSB] == b[MSB]) && (add_s[MSB] != a[MSB]);
            end
            OP_LUI:  sc_lo = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_lo = b << sa;
            OP_SUB: begin
                sc_lo = sub_s[MSB:0];
                sc_cy = sub_s[WIDTH];
                sc_ov = (a[MSB] != b[MSB]) && (sub_s[MSB] != a[MSB]);
            end
            OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  sc_lo = ~(a | b);
            OP_XOR:  sc_lo = a ^ b;
            OP_SRA:  sc_lo = $unsigned($signed(b) >>> sa);
            OP_SRL:  sc_lo = b >> sa;
            default: sc_lo = '0;
        endcase
    end

    // Iterative ops run on magnitudes; signs are reapplied in FIX.
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MC_ALU_DIV_EN
        is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
        is_div = 1'b0;
`endif
        is_sgn = (op == OP_MULT) || (op == OP_DIV);
        a_mag  = (is_sgn && a[MSB]) ? (~a + ONE_W) : a;
        b_mag  = (is_sgn && b[MSB]) ? (~b + ONE_W) : b;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`ifdef MC_ALU_DIV_EN
        div_trial = {1'b0, hi_q, lo_q[MSB]} - {2'b00, mcand_q};
`endif
    end

    always_comb begin
        prod_neg = ~{hi_q, lo_q} + ONE_2W;
        fix_lo   = neg_lo_q ? prod_neg[MSB:0] : lo_q;
        fix_hi   = neg_lo_q ? prod_neg[2*WIDTH-1:WIDTH] : hi_q;
        fix_ov   = 1'b0;
`ifdef MC_ALU_DIV_EN
        if (div_mode_q) begin
            fix_lo = neg_lo_q ? (~lo_q + ONE_W) : lo_q;
            fix_hi = neg_hi_q ? (~hi_q + ONE_W) : hi_q;
            if (div_zero_q) begin
                fix_lo = '1;
            end
            fix_ov = div_exc_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        neg_lo_d    = neg_lo_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        cy_d        = cy_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
`ifdef MC_ALU_DIV_EN
        neg_hi_d    = neg_hi_q;
        div_zero_d  = div_zero_q;
        div_exc_d   = div_exc_q;
        div_mode_d  = div_mode_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) begin
                    if (is_mul) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        hi_d     = '0;
                        lo_d     = b_mag;
                        mcand_d  = a_mag;
                        neg_lo_d = is_sgn && (a[MSB] ^ b[MSB]);
`ifdef MC_ALU_DIV_EN
                        div_mode_d = 1'b0;
`endif
                    end else if (is_div) begin
`ifdef MC_ALU_DIV_EN
                        state_d    = S_DIV;
                        cnt_d      = '0;
                        hi_d       = '0;
                        lo_d       = a_mag;
                        mcand_d    = b_mag;
                        neg_lo_d   = is_sgn && (a[MSB] ^ b[MSB]);
                        neg_hi_d   = is_sgn && a[MSB];
                        div_zero_d = (b == '0);
                        div_exc_d  = (b == '0) ||
                                     (is_sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1));
                        div_mode_d = 1'b1;
`endif
                    end else begin
                        res_lo_d    = sc_lo;
                        res_hi_d    = '0;
                        zero_d      = (sc_lo == '0);
                        ovf_d       = sc_ov;
                        cy_d        = sc_cy;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[MSB:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
`ifdef MC_ALU_DIV_EN
            S_DIV: begin
                // A zero divisor makes every trial succeed, shifting the dividend into hi.
                if (!div_trial[WIDTH+1]) begin
                    hi_d = div_trial[MSB:0];
                    lo_d = {lo_q[MSB-1:0], 1'b1};
                end else begin
                    hi_d = {hi_q[MSB-1:0], lo_q[MSB]};
                    lo_d = {lo_q[MSB-1:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
`endif
            S_FIX: begin
                if (!out_valid_q || out_ready) begin
                    res_lo_d    = fix_lo;
                    res_hi_d    = fix_hi;
                    zero_d      = (fix_lo == '0);
                    ovf_d       = fix_ov;
                    cy_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            neg_lo_q    <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            cy_q        <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MC_ALU_DIV_EN
            neg_hi_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            div_exc_q   <= 1'b0;
            div_mode_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            neg_lo_q    <= neg_lo_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            cy_q        <= cy_d;
            out_valid_q <= out_valid_d;
`ifdef MC_ALU_DIV_EN
            neg_hi_q    <= neg_hi_d;
            div_zero_q  <= div_zero_d;
            div_exc_q   <= div_exc_d;
            div_mode_q  <= div_mode_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carryout  = cy_q;

endmodule
